axi4lite_slave_regs: RTL and testbench

AXI4LITE_SLAVE_REGS -- requirements
Module: axi4lite_slave_regs

---
 rtl/wb_axi_pkg.sv | 15 +
 rtl/axil_reg_bank.sv | 38 +++
 rtl/axi4lite_slave_regs.sv | 138 +++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_axi_pkg.sv
// Shared AXI4-Lite response codes and handshake FSM state types for the register slave.
package wb_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_t;

    // In-range accesses always answer OKAY; out-of-range ones answer SLVERR only when enabled.
    function automatic logic [1:0] range_resp(input logic in_range, input logic slverr_en);
        return (in_range || !slverr_en) ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage for the AXI4-Lite slave: per-byte write enables, combinational read port
// and a flattened view of every register.
module axil_reg_bank #(
    parameter int DW    = 32,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wr_idx,
    input  logic [DW-1:0]            wr_data,
    input  logic [DW/8-1:0]          wr_strb,
    input  logic [$clog2(NREGS)-1:0] rd_idx,
    output logic [DW-1:0]            rd_data,
    output logic [NREGS*DW-1:0]      regs_flat
);

    logic [DW-1:0] mem [NREGS];

    // NOTE: this array is built from flops rather than a RAM macro, so clearing it on reset is legal;
    // reset takes priority over we, which is what drops a write caught by reset mid-handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) mem[k] <= '0;
        end else if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[k*DW +: DW] = mem[k];
    end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register slave with independent write and read handshake FSMs.
// Define WB_AXI_REGS_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4lite_slave_regs
    import wb_axi_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NREGS = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [AW-1:0]       s_axi_awaddr,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DW-1:0]       s_axi_wdata,
    input  logic [DW/8-1:0]     s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [AW-1:0]       s_axi_araddr,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DW-1:0]       s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [NREGS*DW-1:0] regs_o
);

    localparam int IW = $clog2(NREGS);

`ifdef WB_AXI_REGS_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    w_state_t      w_state;
    r_state_t      r_state;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] r_idx;
    logic          w_in_range;
    logic          r_in_range;
    logic          bank_we;
    logic [DW-1:0] bank_rd_data;

    // Byte offset bits are don't-care; anything above the index field must be zero to hit a register.
    assign w_idx      = s_axi_awaddr[IW+1:2];
    assign r_idx      = s_axi_araddr[IW+1:2];
    assign w_in_range = (s_axi_awaddr[AW-1:IW+2] == '0);
    assign r_in_range = (s_axi_araddr[AW-1:IW+2] == '0);
    assign bank_we    = (w_state == W_ACK) && w_in_range;

    // Protection bits and sub-word address bits carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    axil_reg_bank #(
        .DW    (DW),
        .NREGS (NREGS)
    ) u_bank (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .we        (bank_we),
        .wr_idx    (w_idx),
        .wr_data   (s_axi_wdata),
        .wr_strb   (s_axi_wstrb),
        .rd_idx    (r_idx),
        .rd_data   (bank_rd_data),
        .regs_flat (regs_o)
    );

    // NOTE: state and outputs update with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
                    w_state       <= W_ACK;
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b1;
                end
                W_ACK: begin
                    w_state       <= W_RESP;
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b1;
                    s_axi_bresp   <= range_resp(w_in_range, SLVERR_EN);
                end
                W_RESP: if (s_axi_bready) begin
                    w_state      <= W_IDLE;
                    s_axi_bvalid <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Capture happens on the same edge a write may commit, so reads see the pre-write value.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s_axi_arvalid) begin
                    r_state       <= R_ACK;
                    s_axi_arready <= 1'b1;
                end
                R_ACK: begin
                    r_state       <= R_RESP;
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b1;
                    s_axi_rdata   <= r_in_range ? bank_rd_data : '0;
                    s_axi_rresp   <= range_resp(r_in_range, SLVERR_EN);
                end
                R_RESP: if (s_axi_rready) begin
                    r_state      <= R_IDLE;
                    s_axi_rvalid <= 1'b0;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench for axi4lite_slave_regs: directed and random AXI4-Lite traffic against a
// register-array model; inputs change and outputs are sampled on the falling clock edge.
module tb_axi4lite_slave_regs;

    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int NREGS  = 8;
    localparam int FLAT_W = NREGS * DW;

`ifdef WB_AXI_REGS_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic [AW-1:0]     s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DW-1:0]     s_axi_wdata;
    logic [DW/8-1:0]   s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [AW-1:0]     s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [FLAT_W-1:0] regs_o;

    axi4lite_slave_regs #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .regs_o        (regs_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Reference register file plus one pending commit that lands on the next rising edge.
    logic [DW-1:0]   model [NREGS];
    bit              pend_valid = 1'b0;
    int              pend_idx;
    logic [DW-1:0]   pend_data;
    logic [DW/8-1:0] pend_strb;
    bit              cmp_en = 1'b0;

    task automatic check(input string name, input logic [FLAT_W-1:0] actual, input logic [FLAT_W-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit in_range(input logic [AW-1:0] addr);
        return addr < AW'(4 * NREGS);
    endfunction

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int k = 0; k < NREGS; k++) f[k*DW +: DW] = model[k];
        return f;
    endfunction

    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < NREGS; k++) model[k] <= '0;
            pend_valid <= 1'b0;
        end else if (pend_valid) begin
            logic [DW-1:0] merged;
            merged = model[pend_idx];
            for (int b = 0; b < DW/8; b++)
                if (pend_strb[b]) merged[8*b +: 8] = pend_data[8*b +: 8];
            model[pend_idx] <= merged;
            pend_valid      <= 1'b0;
        end
    end

    always @(negedge wb_clk_i) begin
        if (cmp_en) check("regs_o", regs_o, model_flat());
    end

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, input int aw_lead, input int bdelay);
        logic [1:0] exp_resp;
        exp_resp      = in_range(addr) ? 2'b00 : ERR_RESP;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_bready  = (bdelay == 0);
        for (int i = 0; i < aw_lead; i++) begin
            @(negedge wb_clk_i);
            check("awready_aw_only", s_axi_awready, 0);
            check("wready_aw_only", s_axi_wready, 0);
        end
        s_axi_wvalid = 1'b1;
        @(negedge wb_clk_i);
        check("awready_pulse", s_axi_awready, 1);
        check("wready_pulse", s_axi_wready, 1);
        check("bvalid_early", s_axi_bvalid, 0);
        if (in_range(addr)) begin
            pend_idx   = int'(addr >> 2);
            pend_data  = data;
            pend_strb  = strb;
            pend_valid = 1'b1;
        end
        @(negedge wb_clk_i);
        check("awready_drop", s_axi_awready, 0);
        check("wready_drop", s_axi_wready, 0);
        check("bvalid_rise", s_axi_bvalid, 1);
        check("bresp", s_axi_bresp, exp_resp);
        if (bdelay > 0) begin
            // A second request offered while the response stalls must not be taken.
            s_axi_awaddr = AW'(4 * $urandom_range(0, NREGS-1));
            s_axi_wdata  = $urandom();
            s_axi_wstrb  = 4'hF;
            repeat (bdelay) begin
                @(negedge wb_clk_i);
                check("bvalid_hold", s_axi_bvalid, 1);
                check("bresp_hold", s_axi_bresp, exp_resp);
                check("awready_stall", s_axi_awready, 0);
            end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        @(negedge wb_clk_i);
        check("bvalid_clear", s_axi_bvalid, 0);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int rdelay, output logic [DW-1:0] got);
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_resp;
        exp_resp      = in_range(addr) ? 2'b00 : ERR_RESP;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = (rdelay == 0);
        @(negedge wb_clk_i);
        check("arready_pulse", s_axi_arready, 1);
        check("rvalid_early", s_axi_rvalid, 0);
        exp_data = in_range(addr) ? model[int'(addr >> 2)] : '0;
        @(negedge wb_clk_i);
        check("arready_drop", s_axi_arready, 0);
        check("rvalid_rise", s_axi_rvalid, 1);
        check("rdata", s_axi_rdata, exp_data);
        check("rresp", s_axi_rresp, exp_resp);
        got = s_axi_rdata;
        if (rdelay > 0) begin
            s_axi_araddr = AW'(4 * $urandom_range(0, NREGS-1));
            repeat (rdelay) begin
                @(negedge wb_clk_i);
                check("rvalid_hold", s_axi_rvalid, 1);
                check("rdata_hold", s_axi_rdata, exp_data);
                check("rresp_hold", s_axi_rresp, exp_resp);
                check("arready_stall", s_axi_arready, 0);
            end
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        @(negedge wb_clk_i);
        check("rvalid_clear", s_axi_rvalid, 0);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got;
        logic [AW-1:0] addr;

        wb_rst_i      = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awprot  = 3'b000;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arprot  = 3'b000;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        cmp_en = 1'b1;
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_bresp", s_axi_bresp, 2'b00);
        check("rst_arready", s_axi_arready, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rresp", s_axi_rresp, 2'b00);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_regs", regs_o, '0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Reset lands on the edge that would commit a write of all ones to register 2.
        s_axi_awaddr  = 32'h08;
        s_axi_wdata   = 32'hFFFF_FFFF;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        @(negedge wb_clk_i);
        check("abort_awready", s_axi_awready, 1);
        pend_idx   = 2;
        pend_data  = 32'hFFFF_FFFF;
        pend_strb  = 4'hF;
        pend_valid = 1'b1;
        wb_rst_i   = 1'b1;
        @(negedge wb_clk_i);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        wb_rst_i      = 1'b0;
        check("abort_awready_low", s_axi_awready, 0);
        check("abort_wready_low", s_axi_wready, 0);
        check("abort_arready_low", s_axi_arready, 0);
        check("abort_bvalid_low", s_axi_bvalid, 0);
        check("abort_rvalid_low", s_axi_rvalid, 0);
        check("abort_reg2", regs_o[2*DW +: DW], 32'h0);
        repeat (4) begin
            @(negedge wb_clk_i);
            check("abort_no_bvalid", s_axi_bvalid, 0);
        end
        s_axi_bready = 1'b0;

        axi_write(32'h04, 32'h1234_5678, 4'hF, 0, 0);
        check("reg1_full", regs_o[DW +: DW], 32'h1234_5678);
        axi_write(32'h04, 32'hAABB_CCDD, 4'b0101, 0, 0);
        check("reg1_partial", regs_o[DW +: DW], 32'h12BB_56DD);
        axi_read(32'h04, 0, got);
        check("read_reg1", got, 32'h12BB_56DD);

        // Write commit and read capture on the same edge: read returns the old contents.
        s_axi_awaddr  = 32'h04;
        s_axi_wdata   = 32'h0BAD_BEEF;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = 32'h04;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        @(negedge wb_clk_i);
        check("coll_awready", s_axi_awready, 1);
        check("coll_arready", s_axi_arready, 1);
        pend_idx   = 1;
        pend_data  = 32'h0BAD_BEEF;
        pend_strb  = 4'hF;
        pend_valid = 1'b1;
        @(negedge wb_clk_i);
        check("coll_bvalid", s_axi_bvalid, 1);
        check("coll_rvalid", s_axi_rvalid, 1);
        check("coll_rdata_old", s_axi_rdata, 32'h12BB_56DD);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        @(negedge wb_clk_i);
        check("coll_bvalid_clear", s_axi_bvalid, 0);
        check("coll_rvalid_clear", s_axi_rvalid, 0);
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        axi_read(32'h04, 0, got);
        check("coll_read_new", got, 32'h0BAD_BEEF);

        axi_write(32'h0C, 32'hCAFE_F00D, 4'hF, 5, 0);
        axi_write(32'h10, 32'hFFFF_FFFF, 4'h0, 0, 0);
        check("strb0_reg4", regs_o[4*DW +: DW], 32'h0);

        axi_read(32'h40, 0, got);
        check("oor_rdata", got, 32'h0);
        axi_write(32'h40, 32'h5555_AAAA, 4'hF, 0, 0);
        axi_write(32'h8000_0004, 32'h7777_7777, 4'hF, 0, 0);
        axi_read(32'h8000_0000, 2, got);

        axi_write(32'h17, 32'h0102_0304, 4'hF, 0, 10);
        axi_read(32'h14, 10, got);
        check("stall_read_reg5", got, 32'h0102_0304);

        for (int n = 0; n < 200; n++) begin
            addr = ($urandom_range(0, 7) == 0) ? AW'($urandom())
                                                : AW'($urandom_range(0, 8 * NREGS - 1));
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, $urandom(), 4'($urandom()), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                axi_read(addr, $urandom_range(0, 3), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
